// File: rtl/ldpc_syndrome_chk.sv
// rtl/ldpc_syndrome_chk.sv - sequential QC-LDPC syndrome checker, one base-matrix entry per clock
module ldpc_syndrome_chk #(
    parameter int C     = 12,
    parameter int R     = 24,
    parameter int D     = 96,
    parameter int mtx_w = 8,
    parameter int W_w   = $clog2(C*D+1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [C*R*mtx_w-1:0]   m,
    input  logic [R*D-1:0]         s,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             status,
    output logic [W_w-1:0]         syn_weight,
    output logic                   err
);

    localparam int RW = (C > 1) ? $clog2(C) : 1;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [RW-1:0]    R_LAST = RW'(C-1);
    localparam logic [CW-1:0]    C_LAST = CW'(R-1);
    localparam logic [mtx_w-1:0] D_E    = mtx_w'(D);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    c_q, c_d;
    logic [D-1:0]     acc_q, acc_d;
    logic [R*D-1:0]   sreg_q, sreg_d;
    logic [W_w-1:0]   wt_q, wt_d;
    logic             err_q, err_d;
    logic [1:0]       status_q, status_d;

    logic [mtx_w-1:0] entry;
    logic [D-1:0]     blk;
    logic [D-1:0]     contrib;
    logic [D-1:0]     row_vec;
    logic [W_w-1:0]   pc;
    logic             legal;
    logic             illegal;
    logic             row_end;
    logic             last;

    // State and datapath registers; en low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            sreg_q   <= '0;
            wt_q     <= '0;
            err_q    <= 1'b0;
            status_q <= 2'b00;
        end else if (en) begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            acc_q    <= acc_d;
            sreg_q   <= sreg_d;
            wt_q     <= wt_d;
            err_q    <= err_d;
            status_q <= status_d;
        end
    end

    // Rotate the current block-column by the entry shift and popcount the row vector
    always_comb begin
        int idx;
        entry   = m[(int'(r_q)*R + int'(c_q))*mtx_w +: mtx_w];
        blk     = sreg_q[int'(c_q)*D +: D];
        legal   = (entry < D_E);
        illegal = !legal && !(&entry);
        contrib = '0;
        for (int j = 0; j < D; j++) begin
            // j + e < 2D, so one conditional subtract gives the modulo
            idx = legal ? (j + int'(entry)) : j;
            if (idx >= D) idx = idx - D;
            contrib[j] = legal & blk[idx];
        end
        row_vec = acc_q ^ contrib;
        pc = '0;
        for (int j = 0; j < D; j++) begin
            pc = pc + W_w'(row_vec[j]);
        end
        row_end = (c_q == C_LAST);
        last    = row_end && (r_q == R_LAST);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACC;
            S_ACC:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, accumulator and result updates
    always_comb begin
        r_d      = r_q;
        c_d      = c_q;
        acc_d    = acc_q;
        sreg_d   = sreg_q;
        wt_d     = wt_q;
        err_d    = err_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_d   = s;
                    r_d      = '0;
                    c_d      = '0;
                    acc_d    = '0;
                    wt_d     = '0;
                    err_d    = 1'b0;
                    status_d = 2'b00;
                end
            end
            S_ACC: begin
                err_d = err_q | illegal;
                if (row_end) begin
                    wt_d  = wt_q + pc;
                    acc_d = '0;
                    c_d   = '0;
                    if (last) begin
                        r_d      = '0;
                        status_d = ((wt_d == '0) && !err_d) ? 2'b01 : 2'b10;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end else begin
                    acc_d = row_vec;
                    c_d   = c_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and result registers
    always_comb begin
        busy       = (state_q == S_ACC);
        done       = (state_q == S_DONE);
        status     = status_q;
        syn_weight = wt_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_ldpc_syndrome_chk.sv
// tb/tb_ldpc_syndrome_chk.sv - self-checking bench for ldpc_syndrome_chk (small and default configs)
module tb_ldpc_syndrome_chk;

    localparam int SC = 2, SR = 3, SD = 4, SMW = 3, SWW = 4;
    localparam int LC = 12, LR = 24, LD = 96, LMW = 8, LWW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, en, s_start, l_start;
    logic [SC*SR*SMW-1:0]    s_m;
    logic [SR*SD-1:0]        s_s;
    logic                    s_busy, s_done, s_err;
    logic [1:0]              s_status;
    logic [SWW-1:0]          s_wt;
    logic [LC*LR*LMW-1:0]    l_m;
    logic [LR*LD-1:0]        l_s;
    logic                    l_busy, l_done, l_err;
    logic [1:0]              l_status;
    logic [LWW-1:0]          l_wt;

    int checks = 0;
    int errors = 0;

    ldpc_syndrome_chk #(.C(SC), .R(SR), .D(SD), .mtx_w(SMW), .W_w(SWW)) dut_s (
        .clk(clk), .rst(rst), .en(en), .start(s_start), .m(s_m), .s(s_s),
        .busy(s_busy), .done(s_done), .status(s_status), .syn_weight(s_wt), .err(s_err)
    );

    ldpc_syndrome_chk dut_l (
        .clk(clk), .rst(rst), .en(en), .start(l_start), .m(l_m), .s(l_s),
        .busy(l_busy), .done(l_done), .status(l_status), .syn_weight(l_wt), .err(l_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Syndrome weight straight from H*s: row r, check j is the parity of s[c*nd + (j+e)%nd]
    function automatic int model_wt(int nc, int nr, int nd, int mat[$], bit sv[$]);
        int w = 0;
        for (int r = 0; r < nc; r++)
            for (int j = 0; j < nd; j++) begin
                bit p = 0;
                for (int c = 0; c < nr; c++) begin
                    int e = mat[r*nr + c];
                    if (e < nd) p ^= sv[c*nd + (j + e) % nd];
                end
                w += p;
            end
        return w;
    endfunction

    function automatic bit model_err(int nd, int mw, int mat[$]);
        int ones = (1 << mw) - 1;
        foreach (mat[i]) if (mat[i] >= nd && mat[i] != ones) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_small(input string tag, input int mat[$], input logic [11:0] sv,
                             input bit stall, output int got_wt);
        bit q[$];
        int ew, n;
        bit ee;
        for (int i = 0; i < SC*SR; i++) s_m[i*SMW +: SMW] = SMW'(mat[i]);
        for (int i = 0; i < SR*SD; i++) q.push_back(sv[i]);
        ew = model_wt(SC, SR, SD, mat, q);
        ee = model_err(SD, SMW, mat);
        s_s = sv;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        n = 1;
        while (!s_done && n < 60) begin
            s_s = 12'($urandom);
            if (stall) begin
                if (n == 2) en = 1'b0;
                if (n == 5) en = 1'b1;
                s_start = (n == 3 || n == 6);
            end
            tick;
            n++;
        end
        s_start = 1'b0;
        chk({tag, "_latency"}, n, stall ? 10 : 7);
        chk({tag, "_busy_at_done"}, s_busy, 0);
        chk({tag, "_status"}, s_status, (ew == 0 && !ee) ? 1 : 2);
        chk({tag, "_weight"}, s_wt, ew);
        chk({tag, "_err"}, s_err, ee);
        got_wt = s_wt;
        tick;
        chk({tag, "_done_single"}, s_done, 0);
        chk({tag, "_status_hold"}, s_status, (ew == 0 && !ee) ? 1 : 2);
    endtask

    task automatic run_large(input string tag, input int mat[$], input bit sv[$], output int got_wt);
        int ew, n;
        for (int i = 0; i < LC*LR; i++) l_m[i*LMW +: LMW] = LMW'(mat[i]);
        for (int i = 0; i < LR*LD; i++) l_s[i] = sv[i];
        ew = model_wt(LC, LR, LD, mat, sv);
        l_start = 1'b1;
        tick;
        l_start = 1'b0;
        n = 1;
        while (!l_done && n < 400) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 289);
        chk({tag, "_status"}, l_status, (ew == 0) ? 1 : 2);
        chk({tag, "_weight"}, l_wt, ew);
        chk({tag, "_err"}, l_err, 0);
        got_wt = l_wt;
        tick;
    endtask

    initial begin
        int base[$];
        int bad[$];
        int rmat[$];
        int lmat[$];
        bit lsv[$];
        int w, n, dones, col, bitn, cnt;

        base = '{0, 1, 7, 2, 7, 0};
        bad  = '{0, 1, 7, 2, 5, 0};
        rst = 1'b1; en = 1'b1; s_start = 1'b0; l_start = 1'b0;
        s_m = '0; s_s = '0; l_m = '0; l_s = '0;
        tick; tick;
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_status", s_status, 0);
        chk("rst_weight", s_wt, 0);
        chk("rst_err", s_err, 0);
        chk("rst_l_busy", l_busy, 0);
        chk("rst_l_status", l_status, 0);
        rst = 1'b0;
        tick;

        run_small("zero", base, 12'h000, 1'b0, w);
        run_small("bit0", base, 12'h001, 1'b0, w);
        chk("bit0_weight_const", w, 2);
        run_small("illegal", bad, 12'h000, 1'b0, w);
        chk("illegal_err_const", s_err, 1);
        chk("illegal_weight_const", w, 0);
        run_small("stall", base, 12'($urandom), 1'b1, w);

        // Reset mid-operation with an illegal entry at (0,0) so err is already set
        s_m = '0;
        for (int i = 0; i < 6; i++) s_m[i*SMW +: SMW] = SMW'(i == 0 ? 5 : base[i]);
        s_s = 12'hFFF;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        tick; tick; tick;
        chk("pre_rst_err", s_err, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", s_busy, 0);
        chk("midrst_done", s_done, 0);
        chk("midrst_status", s_status, 0);
        chk("midrst_weight", s_wt, 0);
        chk("midrst_err", s_err, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (s_done) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run_small("after_rst", base, 12'h801, 1'b0, w);

        rst = 1'b1; s_start = 1'b1;
        tick;
        rst = 1'b0; s_start = 1'b0;
        chk("rst_start_busy", s_busy, 0);
        tick;
        chk("rst_start_busy2", s_busy, 0);

        for (int k = 0; k < 6; k++) begin
            rmat = {};
            for (int i = 0; i < 6; i++) begin
                n = $urandom_range(0, 9);
                rmat.push_back(n <= 3 ? n : (n <= 7 ? 7 : $urandom_range(4, 6)));
            end
            run_small($sformatf("rand%0d", k), rmat, 12'($urandom), 1'b0, w);
        end

        for (int i = 0; i < LC*LR; i++)
            lmat.push_back($urandom_range(0, 3) == 0 ? 255 : $urandom_range(0, LD-1));
        for (int i = 0; i < LR*LD; i++) lsv.push_back(1'b0);
        run_large("big_zero", lmat, lsv, w);

        col  = $urandom_range(0, LR-1);
        bitn = $urandom_range(0, LD-1);
        lsv[col*LD + bitn] = 1'b1;
        cnt = 0;
        for (int r = 0; r < LC; r++) if (lmat[r*LR + col] != 255) cnt++;
        run_large("big_flip", lmat, lsv, w);
        chk("big_flip_colcount", w, cnt);

        for (int i = 0; i < LR*LD; i++) lsv[i] = 1'($urandom);
        run_large("big_rand", lmat, lsv, w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
